// File: rtl/idli_mem_seq_m_if.sv
// Request/transfer bundle between decode, the multi-register sequencer and execute.
interface idli_mem_seq_m_if #(
  parameter int REG_W = 3,
  parameter int CTR_W = 2
);
  logic [CTR_W-1:0] i_ms_ctr;
  logic             i_ms_stall;
  logic             i_ms_redirect;
  logic             i_ms_start;
  logic             i_ms_st;
  logic             i_ms_dir;
  logic [REG_W-1:0] i_ms_first_reg;
  logic [REG_W-1:0] i_ms_last_reg;
  logic             o_ms_busy;
  logic             o_ms_op_vld;
  logic             o_ms_op_st;
  logic [REG_W-1:0] o_ms_reg;
  logic             o_ms_first;
  logic             o_ms_last;
  logic             o_ms_post;
  logic             o_ms_done;

  // Sequencer side
  modport slave (
    input  i_ms_ctr, i_ms_stall, i_ms_redirect, i_ms_start,
    input  i_ms_st, i_ms_dir, i_ms_first_reg, i_ms_last_reg,
    output o_ms_busy, o_ms_op_vld, o_ms_op_st, o_ms_reg,
    output o_ms_first, o_ms_last, o_ms_post, o_ms_done
  );

  // Decode/execute side
  modport master (
    output i_ms_ctr, i_ms_stall, i_ms_redirect, i_ms_start,
    output i_ms_st, i_ms_dir, i_ms_first_reg, i_ms_last_reg,
    input  o_ms_busy, o_ms_op_vld, o_ms_op_st, o_ms_reg,
    input  o_ms_first, o_ms_last, o_ms_post, o_ms_done
  );
endinterface

// File: rtl/idli_mem_seq_m.sv
// Multi-register load/store sequencer: expands one LDM/STM-style request into one
// transfer op per register (ascending or descending, with wrap and an optional
// skipped register), followed by an optional post-memory op.
module idli_mem_seq_m #(
  parameter int NUM_REGS    = 8,
  parameter int REG_W       = $clog2(NUM_REGS),
  parameter int CTR_W       = 2,
  parameter int POST_OP     = 1,
  parameter int SKIP_REG_EN = 0,
  parameter int SKIP_REG    = 0
) (
  input  logic              i_ms_gck,
  input  logic              i_ms_rst_n,
  idli_mem_seq_m_if.slave   ms
);

  localparam logic [REG_W-1:0] SKIP_IDX = REG_W'(SKIP_REG);
  localparam bit               SKIP_ON  = (SKIP_REG_EN != 0);
  localparam bit               POST_ON  = (POST_OP != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_POST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             st_q, st_d;
  logic             dir_q, dir_d;
  logic             first_q, first_d;
  logic [REG_W-1:0] last_q, last_d;
  logic [REG_W-1:0] reg_q, reg_d;

  logic             end_op;
  logic             start_acc;
  logic             range_empty;
  logic             is_last;
  logic [REG_W-1:0] start_reg;

  // One register step in the chosen direction; wraps naturally since NUM_REGS is a power of two.
  function automatic logic [REG_W-1:0] step_reg(input logic [REG_W-1:0] r, input logic desc);
    return desc ? (r - REG_W'(1)) : (r + REG_W'(1));
  endfunction

  // Step, then step once more if we landed on the skipped register.
  function automatic logic [REG_W-1:0] next_reg(input logic [REG_W-1:0] r, input logic desc);
    logic [REG_W-1:0] s;
    s = step_reg(r, desc);
    if (SKIP_ON && (s == SKIP_IDX)) s = step_reg(s, desc);
    return s;
  endfunction

  // Decode of the op boundary, request acceptance and end-of-range conditions.
  always_comb begin
    end_op      = (&ms.i_ms_ctr) && !ms.i_ms_stall;
    start_acc   = (state_q == ST_IDLE) && ms.i_ms_start && !ms.i_ms_redirect;
    start_reg   = (SKIP_ON && (ms.i_ms_first_reg == SKIP_IDX))
                  ? step_reg(ms.i_ms_first_reg, ms.i_ms_dir) : ms.i_ms_first_reg;
    // Only a range consisting of just the skipped register has nothing to transfer.
    range_empty = SKIP_ON && (ms.i_ms_first_reg == SKIP_IDX) && (ms.i_ms_last_reg == SKIP_IDX);
    // When last is the skipped register, the walk ends on the register just before it.
    is_last     = (reg_q == last_q) ||
                  (SKIP_ON && (last_q == SKIP_IDX) && (step_reg(reg_q, dir_q) == SKIP_IDX));
  end

  // Next-state logic; redirect overrides every other transition.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    dir_d   = dir_q;
    first_d = first_q;
    last_d  = last_q;
    reg_d   = reg_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          st_d    = ms.i_ms_st;
          dir_d   = ms.i_ms_dir;
          last_d  = ms.i_ms_last_reg;
          reg_d   = start_reg;
          first_d = 1'b1;
          if (range_empty) state_d = POST_ON ? ST_POST : ST_IDLE;
          else             state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (end_op) begin
          first_d = 1'b0;
          if (is_last) state_d = POST_ON ? ST_POST : ST_IDLE;
          else         reg_d   = next_reg(reg_q, dir_q);
        end
      end
      ST_POST: begin
        if (end_op) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ms.i_ms_redirect) state_d = ST_IDLE;
  end

  // State and captured request fields; async reset drops everything to IDLE at once.
  always_ff @(posedge i_ms_gck or negedge i_ms_rst_n) begin
    if (!i_ms_rst_n) begin
      state_q <= ST_IDLE;
      st_q    <= 1'b0;
      dir_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      last_q  <= last_d;
      reg_q   <= reg_d;
    end
  end

  // Outputs decoded from flops; done is the only one that looks at current-cycle inputs.
  always_comb begin
    ms.o_ms_busy   = (state_q != ST_IDLE);
    ms.o_ms_op_vld = (state_q == ST_XFER);
    ms.o_ms_op_st  = (state_q == ST_XFER) && st_q;
    ms.o_ms_reg    = (state_q == ST_XFER) ? reg_q : '0;
    ms.o_ms_first  = (state_q == ST_XFER) && first_q;
    ms.o_ms_last   = (state_q == ST_XFER) && is_last;
    ms.o_ms_post   = (state_q == ST_POST);
    ms.o_ms_done   = !ms.i_ms_redirect &&
                     ((start_acc && range_empty && !POST_ON) ||
                      (end_op && (((state_q == ST_XFER) && is_last && !POST_ON) ||
                                  (state_q == ST_POST))));
  end

endmodule

// File: tb/tb_idli_mem_seq_m.sv
// Directed bench: three sequencer instances (default, skip r0, no post op) share
// one stimulus stream; per-run traces are compared against hand-computed tables.
module tb_idli_mem_seq_m;

  logic       clk;
  logic       rst_n;
  logic [1:0] ctr;
  logic       stall, redirect, start, st, dir;
  logic [2:0] first_r, last_r;

  int n_pass   = 0;
  int n_checks = 0;

  logic       busy_s [3];
  logic       vld_s  [3];
  logic       ost_s  [3];
  logic [2:0] reg_s  [3];
  logic       first_s[3];
  logic       last_s [3];
  logic       post_s [3];
  logic       done_s [3];
  logic [9:0] outw_s [3];

  int regs_o[3], nvld_o[3], npost_o[3], done_o[3], ndone_o[3];
  int nfirst_o[3], freg_o[3], nlast_o[3], lreg_o[3], idle_o[3], stbad_o[3];
  logic cur_st;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  idli_mem_seq_m_if #(.REG_W(3), .CTR_W(2)) ifs [3] ();

  for (genvar gi = 0; gi < 3; gi++) begin : g_conn
    assign ifs[gi].i_ms_ctr       = ctr;
    assign ifs[gi].i_ms_stall     = stall;
    assign ifs[gi].i_ms_redirect  = redirect;
    assign ifs[gi].i_ms_start     = start;
    assign ifs[gi].i_ms_st        = st;
    assign ifs[gi].i_ms_dir       = dir;
    assign ifs[gi].i_ms_first_reg = first_r;
    assign ifs[gi].i_ms_last_reg  = last_r;
    assign busy_s[gi]  = ifs[gi].o_ms_busy;
    assign vld_s[gi]   = ifs[gi].o_ms_op_vld;
    assign ost_s[gi]   = ifs[gi].o_ms_op_st;
    assign reg_s[gi]   = ifs[gi].o_ms_reg;
    assign first_s[gi] = ifs[gi].o_ms_first;
    assign last_s[gi]  = ifs[gi].o_ms_last;
    assign post_s[gi]  = ifs[gi].o_ms_post;
    assign done_s[gi]  = ifs[gi].o_ms_done;
    assign outw_s[gi]  = {ifs[gi].o_ms_busy, ifs[gi].o_ms_op_vld, ifs[gi].o_ms_op_st,
                          ifs[gi].o_ms_reg, ifs[gi].o_ms_first, ifs[gi].o_ms_last,
                          ifs[gi].o_ms_post, ifs[gi].o_ms_done};
  end

  idli_mem_seq_m #(.NUM_REGS(8), .CTR_W(2), .POST_OP(1), .SKIP_REG_EN(0), .SKIP_REG(0))
    dut_a (.i_ms_gck(clk), .i_ms_rst_n(rst_n), .ms(ifs[0]));
  idli_mem_seq_m #(.NUM_REGS(8), .CTR_W(2), .POST_OP(1), .SKIP_REG_EN(1), .SKIP_REG(0))
    dut_b (.i_ms_gck(clk), .i_ms_rst_n(rst_n), .ms(ifs[1]));
  idli_mem_seq_m #(.NUM_REGS(8), .CTR_W(2), .POST_OP(0), .SKIP_REG_EN(0), .SKIP_REG(0))
    dut_c (.i_ms_gck(clk), .i_ms_rst_n(rst_n), .ms(ifs[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to the next cycle; the core counter holds while the previous cycle stalled.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (!stall) ctr = ctr + 2'd1;
  endtask

  task automatic sample(input int k);
    for (int i = 0; i < 3; i++) begin
      if (vld_s[i]) begin
        nvld_o[i]++;
        if (ost_s[i] !== cur_st) stbad_o[i]++;
        if (ctr == 2'd3 && !stall) regs_o[i] = regs_o[i] * 16 + int'(reg_s[i]);
      end
      if (first_s[i]) begin
        nfirst_o[i]++;
        if (freg_o[i] < 0) freg_o[i] = int'(reg_s[i]);
      end
      if (last_s[i]) begin
        nlast_o[i]++;
        lreg_o[i] = int'(reg_s[i]);
      end
      if (post_s[i]) npost_o[i]++;
      if (done_s[i]) begin
        ndone_o[i]++;
        done_o[i] = k;
      end
      if (k >= 1 && !busy_s[i] && idle_o[i] < 0) idle_o[i] = k;
    end
  endtask

  // Issue one request on the next all-ones counter cycle and trace it to completion.
  task automatic run_seq(input logic s, input logic d, input logic [2:0] f, input logic [2:0] l,
                         input int stall_k, input int stall_n, input int redir_k, input string tag);
    int finished;
    for (int i = 0; i < 3; i++) begin
      regs_o[i] = 1; nvld_o[i] = 0; npost_o[i] = 0; done_o[i] = -1; ndone_o[i] = 0;
      nfirst_o[i] = 0; freg_o[i] = -1; nlast_o[i] = 0; lreg_o[i] = -1; idle_o[i] = -1;
      stbad_o[i] = 0;
    end
    cur_st = s;
    finished = 0;
    next_cycle();
    while (ctr != 2'd3) next_cycle();
    start = 1'b1; st = s; dir = d; first_r = f; last_r = l; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    sample(0);
    for (int k = 1; k <= 60; k++) begin
      next_cycle();
      start    = 1'b0;
      stall    = (k >= stall_k) && (k < stall_k + stall_n);
      redirect = (k == redir_k);
      @(negedge clk);
      sample(k);
      if (!busy_s[0] && !busy_s[1] && !busy_s[2]) begin
        finished = 1;
        break;
      end
    end
    stall = 1'b0;
    redirect = 1'b0;
    chk({tag, " completes"}, finished, 1);
  endtask

  task automatic check_run(input string tag, input int i, input int regs, input int nvld,
                           input int npost, input int done_at, input int nfirst, input int freg,
                           input int nlast, input int lreg, input int idle_at);
    string t;
    t = $sformatf("%s/dut%0d", tag, i);
    $display("run %s regs=%0h vld=%0d post=%0d done@%0d first=%0d/r%0d last=%0d/r%0d idle@%0d",
             t, regs_o[i], nvld_o[i], npost_o[i], done_o[i], nfirst_o[i], freg_o[i],
             nlast_o[i], lreg_o[i], idle_o[i]);
    chk({t, " regs"},      regs_o[i],   regs);
    chk({t, " op_vld"},    nvld_o[i],   nvld);
    chk({t, " post"},      npost_o[i],  npost);
    chk({t, " done_at"},   done_o[i],   done_at);
    chk({t, " done_cnt"},  ndone_o[i],  (done_at >= 0) ? 1 : 0);
    chk({t, " first_cnt"}, nfirst_o[i], nfirst);
    chk({t, " first_reg"}, freg_o[i],   freg);
    chk({t, " last_cnt"},  nlast_o[i],  nlast);
    chk({t, " last_reg"},  lreg_o[i],   lreg);
    chk({t, " idle_at"},   idle_o[i],   idle_at);
    chk({t, " op_st"},     stbad_o[i],  0);
  endtask

  initial begin
    rst_n = 1'b0; ctr = 2'd0; stall = 1'b0; redirect = 1'b0; start = 1'b0;
    st = 1'b0; dir = 1'b0; first_r = 3'd0; last_r = 3'd0; cur_st = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset/dut%0d outputs", i), int'(outw_s[i]), 0);
    rst_n = 1'b1;

    // 1: LD ascending r2..r4
    run_seq(1'b0, 1'b0, 3'd2, 3'd4, -1, 0, -1, "ld_asc_2_4");
    check_run("ld_asc_2_4", 0, 'h1234, 12, 4, 16, 4, 2, 4, 4, 17);
    check_run("ld_asc_2_4", 1, 'h1234, 12, 4, 16, 4, 2, 4, 4, 17);
    check_run("ld_asc_2_4", 2, 'h1234, 12, 0, 12, 4, 2, 4, 4, 13);

    // 2: ST ascending r6..r1 with wrap; r0 skipped on dut1
    run_seq(1'b1, 1'b0, 3'd6, 3'd1, -1, 0, -1, "st_asc_6_1");
    check_run("st_asc_6_1", 0, 'h16701, 16, 4, 20, 4, 6, 4, 1, 21);
    check_run("st_asc_6_1", 1, 'h1671,  12, 4, 16, 4, 6, 4, 1, 17);
    check_run("st_asc_6_1", 2, 'h16701, 16, 0, 16, 4, 6, 4, 1, 17);

    // 2b: last register is the skipped one; dut1 ends on r7
    run_seq(1'b1, 1'b0, 3'd6, 3'd0, -1, 0, -1, "st_asc_6_0");
    check_run("st_asc_6_0", 0, 'h1670, 12, 4, 16, 4, 6, 4, 0, 17);
    check_run("st_asc_6_0", 1, 'h167,   8, 4, 12, 4, 6, 4, 7, 13);
    check_run("st_asc_6_0", 2, 'h1670, 12, 0, 12, 4, 6, 4, 0, 13);

    // 3: LD descending r5..r3
    run_seq(1'b0, 1'b1, 3'd5, 3'd3, -1, 0, -1, "ld_desc_5_3");
    check_run("ld_desc_5_3", 0, 'h1543, 12, 4, 16, 4, 5, 4, 3, 17);
    check_run("ld_desc_5_3", 1, 'h1543, 12, 4, 16, 4, 5, 4, 3, 17);
    check_run("ld_desc_5_3", 2, 'h1543, 12, 0, 12, 4, 5, 4, 3, 13);

    // 3b: descending r1..r7 wrapping through r0
    run_seq(1'b0, 1'b1, 3'd1, 3'd7, -1, 0, -1, "ld_desc_1_7");
    check_run("ld_desc_1_7", 0, 'h1107, 12, 4, 16, 4, 1, 4, 7, 17);
    check_run("ld_desc_1_7", 1, 'h117,   8, 4, 12, 4, 1, 4, 7, 13);
    check_run("ld_desc_1_7", 2, 'h1107, 12, 0, 12, 4, 1, 4, 7, 13);

    // 4: redirect on ctr==1 of r3 in r2..r5, then a fresh request on the next all-ones ctr
    run_seq(1'b0, 1'b0, 3'd2, 3'd5, -1, 0, 6, "redirect");
    for (int i = 0; i < 3; i++) check_run("redirect", i, 'h12, 6, 0, -1, 4, 2, 0, -1, 7);
    run_seq(1'b0, 1'b1, 3'd5, 3'd3, -1, 0, -1, "after_redir");
    check_run("after_redir", 0, 'h1543, 12, 4, 16, 4, 5, 4, 3, 17);
    check_run("after_redir", 1, 'h1543, 12, 4, 16, 4, 5, 4, 3, 17);
    check_run("after_redir", 2, 'h1543, 12, 0, 12, 4, 5, 4, 3, 13);

    // 5: stall for 3 cycles at ctr==3 of r2 in r2..r3
    run_seq(1'b0, 1'b0, 3'd2, 3'd3, 4, 3, -1, "stall");
    check_run("stall", 0, 'h123, 11, 4, 15, 7, 2, 4, 3, 16);
    check_run("stall", 1, 'h123, 11, 4, 15, 7, 2, 4, 3, 16);
    check_run("stall", 2, 'h123, 11, 0, 11, 7, 2, 4, 3, 12);

    // 5b: range r0..r0; empty on dut1 so it goes straight to the post op
    run_seq(1'b0, 1'b0, 3'd0, 3'd0, -1, 0, -1, "range_0_0");
    check_run("range_0_0", 0, 'h10, 4, 4, 8, 4, 0, 4, 0, 9);
    check_run("range_0_0", 1, 'h1,  0, 4, 4, 0, -1, 0, -1, 5);
    check_run("range_0_0", 2, 'h10, 4, 0, 4, 4, 0, 4, 0, 5);

    // 6: async reset in the middle of a transfer
    next_cycle();
    while (ctr != 2'd3) next_cycle();
    start = 1'b1; st = 1'b1; dir = 1'b0; first_r = 3'd2; last_r = 3'd4;
    next_cycle();
    start = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("pre_reset busy", int'(busy_s[0]), 1);
    chk("pre_reset reg", int'(reg_s[0]), 2);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("async_reset/dut%0d outputs", i), int'(outw_s[i]), 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, 1'b0, 3'd2, 3'd4, -1, 0, -1, "after_reset");
    check_run("after_reset", 0, 'h1234, 12, 4, 16, 4, 2, 4, 4, 17);
    check_run("after_reset", 1, 'h1234, 12, 4, 16, 4, 2, 4, 4, 17);
    check_run("after_reset", 2, 'h1234, 12, 0, 12, 4, 2, 4, 4, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
